// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: one addr_ok/data_ok memory port shared by
// fetch and load/store, responses routed back in grant order.
module sram_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    G_DATA,
    G_INST
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] owner;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;

  logic gnt_data;
  logic gnt_inst;
  logic room;
  logic accept;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign gnt_data = (state == G_DATA);
  assign gnt_inst = (state == G_INST);
  assign room     = (count < FULL);
  assign accept   = mem_req && mem_addr_ok;
  assign pop      = mem_data_ok && (count != '0);
  // a full FIFO can only take a push that frees a slot the same cycle
  assign push     = accept && (room || pop);
  assign head     = owner[rptr];

  // grant FSM: data has fixed priority, one grant per transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_sram_req && room)
            state <= G_DATA;
          else if (inst_sram_req && room)
            state <= G_INST;
        end
        G_DATA: begin
          if (accept || !data_sram_req)
            state <= IDLE;
        end
        G_INST: begin
          if (accept || !inst_sram_req)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // steer the granted requester onto the memory port
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    unique case (1'b1)
      gnt_data: begin
        mem_req   = data_sram_req;
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_wstrb = data_sram_wstrb;
        mem_addr  = data_sram_addr;
        mem_wdata = data_sram_wdata;
      end
      gnt_inst: begin
        mem_req   = inst_sram_req;
        mem_size  = 2'b10;
        mem_addr  = inst_sram_addr;
      end
      default: ;
    endcase
  end

  assign data_sram_addr_ok = gnt_data && accept;
  assign inst_sram_addr_ok = gnt_inst && accept;

  assign data_sram_data_ok = pop && head;
  assign inst_sram_data_ok = pop && !head;
  assign data_sram_rdata   = mem_rdata;
  assign inst_sram_rdata   = mem_rdata;

  // owner FIFO: records who each in-flight transaction belongs to
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        owner[wptr] <= gnt_data;
        wptr        <= nxt(wptr);
      end
      if (pop)
        rptr <= nxt(rptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed stimulus, memory responder and
// scoreboard monitor for the shared SRAM port arbiter.
module tb_sram_port_arbiter;

  localparam logic [31:0] KEY = 32'h1E800C0C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req = 1'b0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 1'b0;
  logic        data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = 2'b0;
  logic [3:0]  data_sram_wstrb = 4'b0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  typedef struct packed {
    logic        own;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] sq[$];
  int          sq_t[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 3;
  int outstanding = 0;
  int inst_aok_n = 0;
  int data_dok_n = 0;
  int overlap_n = 0;
  logic acc_en = 1'b1;
  logic data_en = 1'b1;
  logic stray = 1'b0;
  logic ignore_rsp = 1'b0;

  always #5 clk = ~clk;

  assign mem_addr_ok = mem_req & acc_en;

  sram_port_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // memory responder: data_ok once the head has aged lat cycles
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
      if (stray) begin
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hDEADBEEF;
      end else if (data_en && sq.size() > 0) begin
        if (cyc - sq_t[0] >= lat) begin
          mem_data_ok = 1'b1;
          mem_rdata   = sq[0];
        end
      end
    end
  end

  // monitor: scoreboard pops, occupancy model, responder bookkeeping
  initial begin
    logic acc;
    logic done;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        outstanding = 0;
      end else begin
        chk("count", 32'(dut.count), 32'(outstanding));
        if ((inst_sram_data_ok || data_sram_data_ok) && !ignore_rsp) begin
          chk("dual_rsp", 32'(inst_sram_data_ok && data_sram_data_ok), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_owner", 32'(data_sram_data_ok), 32'(e.own));
            chk("rsp_rdata", data_sram_data_ok ? data_sram_rdata
                                               : inst_sram_rdata, e.rdata);
          end
        end
        if (inst_sram_addr_ok) inst_aok_n++;
        if (data_sram_data_ok) data_dok_n++;
        acc  = mem_req && mem_addr_ok;
        done = mem_data_ok && (outstanding > 0);
        if (acc && done && outstanding == 1) overlap_n++;
        if (mem_data_ok && sq.size() > 0) begin
          void'(sq.pop_front());
          void'(sq_t.pop_front());
        end
        if (acc) begin
          sq.push_back(mem_addr ^ KEY);
          sq_t.push_back(cyc);
        end
        outstanding = outstanding + int'(acc) - int'(done);
      end
    end
  end

  task automatic issue(input logic d, input logic wr,
                       input logic [1:0] sz, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic push_exp);
    int   n  = 0;
    logic ok = 1'b0;
    if (push_exp) exp_q.push_back(exp_t'{own: d, rdata: a ^ KEY});
    if (d) begin
      data_sram_req   = 1'b1;
      data_sram_wr    = wr;
      data_sram_size  = sz;
      data_sram_wstrb = be;
      data_sram_addr  = a;
      data_sram_wdata = wd;
    end else begin
      inst_sram_req  = 1'b1;
      inst_sram_addr = a;
    end
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      ok = d ? data_sram_addr_ok : inst_sram_addr_ok;
    end
    chk(d ? "data_grant" : "inst_grant", 32'(ok), 1);
    if (ok) begin
      chk("mem_addr", mem_addr, a);
      chk("mem_wr", 32'(mem_wr), d ? 32'(wr) : 0);
      chk("mem_size", 32'(mem_size), d ? 32'(sz) : 2);
      chk("mem_wstrb", 32'(mem_wstrb), d ? 32'(be) : 0);
      chk("mem_wdata", mem_wdata, d ? wd : 0);
    end
    @(posedge clk);
    #1;
    if (d) data_sram_req = 1'b0;
    else   inst_sram_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int d0;
    int n;
    // reset state with both requesters asking
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_inst_aok", 32'(inst_sram_addr_ok), 0);
    chk("rst_data_aok", 32'(data_sram_addr_ok), 0);
    chk("rst_count", 32'(dut.count), 0);
    @(posedge clk);
    #1;
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: single fetch, grant registered one cycle after req
    n0 = inst_aok_n;
    d0 = data_dok_n;
    exp_q.push_back(exp_t'{own: 1'b0, rdata: 32'h02800C0C});
    fork
      issue(1'b0, 1'b0, 2'b10, 4'h0, 32'h1C000000, 32'h0, 1'b0);
      begin
        @(negedge clk);
        chk("req_same_cycle", 32'(mem_req), 0);
        @(negedge clk);
        chk("req_next_cycle", 32'(mem_req), 1);
      end
    join
    drain();
    chk("inst_aok_pulses", inst_aok_n - n0, 1);
    chk("data_dok_pulses", data_dok_n - d0, 0);

    // 2: simultaneous requests, data granted first
    exp_q.push_back(exp_t'{own: 1'b1, rdata: 32'h02810C0C});
    exp_q.push_back(exp_t'{own: 1'b0, rdata: 32'h02800C08});
    fork
      issue(1'b1, 1'b0, 2'b10, 4'h0, 32'h1C010000, 32'h0, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 4'h0, 32'h1C000004, 32'h0, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!mem_req && n < 10);
        chk("first_grant_addr", mem_addr, 32'h1C010000);
      end
    join
    drain();

    // 3: DEPTH=2 limit with data_ok withheld
    data_en = 1'b0;
    exp_q.push_back(exp_t'{own: 1'b0, rdata: 32'h02800C1C});
    exp_q.push_back(exp_t'{own: 1'b0, rdata: 32'h02800C18});
    exp_q.push_back(exp_t'{own: 1'b0, rdata: 32'h02800C14});
    issue(1'b0, 1'b0, 2'b10, 4'h0, 32'h1C000010, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 2'b10, 4'h0, 32'h1C000014, 32'h0, 1'b0);
    fork
      issue(1'b0, 1'b0, 2'b10, 4'h0, 32'h1C000018, 32'h0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("full_no_req", 32'(mem_req), 0);
        end
        data_en = 1'b1;
      end
    join
    drain();

    // 4: byte store fields pass straight through
    exp_q.push_back(exp_t'{own: 1'b1, rdata: 32'h02820C0C});
    issue(1'b1, 1'b1, 2'b00, 4'b0100, 32'h1C020000,
          32'h00AB0000, 1'b0);
    drain();

    // 5: mixed traffic, lat=2 makes accepts coincide with data_ok
    lat = 2;
    n0 = overlap_n;
    for (int i = 0; i < 20; i++) begin
      logic        d;
      logic [31:0] a;
      d = 1'($urandom_range(0, 1));
      a = 32'h1C030000 + 32'($urandom_range(0, 255)) * 4;
      issue(d, d & 1'($urandom_range(0, 1)), 2'b10, 4'hF, a,
            $urandom, 1'b1);
    end
    drain();
    chk("push_pop_overlap", 32'(overlap_n > n0), 1);
    lat = 3;

    // 6: async reset with two in flight, stray data_ok afterwards
    data_en = 1'b0;
    issue(1'b0, 1'b0, 2'b10, 4'h0, 32'h1C000020, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b10, 4'h0, 32'h1C040000, 32'h0, 1'b0);
    ignore_rsp    = 1'b1;
    stray         = 1'b1;
    inst_sram_req = 1'b1;
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_inst_aok", 32'(inst_sram_addr_ok), 0);
    chk("arst_data_aok", 32'(data_sram_addr_ok), 0);
    chk("arst_inst_dok", 32'(inst_sram_data_ok), 0);
    chk("arst_data_dok", 32'(data_sram_data_ok), 0);
    @(posedge clk);
    #1;
    inst_sram_req = 1'b0;
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_inst_dok", 32'(inst_sram_data_ok), 0);
      chk("stray_data_dok", 32'(data_sram_data_ok), 0);
    end
    stray      = 1'b0;
    ignore_rsp = 1'b0;
    data_en    = 1'b1;
    exp_q.delete();
    sq.delete();
    sq_t.delete();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
